// File: rtl/fetch_pkg.sv
// Purpose : shared types and constants for the instruction-fetch sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t   - sequencer states IDLE / FETCH / UPDATE / HOLD
//   redir_t   - redirect payload {sub, off}
//   pcctl_t   - PC control bundle {inc, add, sub, offset}
//   is_jmp()  - opcode-field compare for fetch-resolved relative jumps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Default opcode marking a relative jump resolved at fetch.
  localparam logic [3:0] JMP_OP_DEF = 4'hF;

  // Jump magnitude width; the bit just above the magnitude selects direction.
  localparam int OFF_W_DEF   = 11;
  localparam int DIR_BIT_DEF = OFF_W_DEF;

  // Opcode field position inside a 16-bit instruction word.
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;

  typedef struct packed {
    logic        sub;
    logic [15:0] off;
  } redir_t;

  typedef struct packed {
    logic        inc;
    logic        add;
    logic        sub;
    logic [15:0] offset;
  } pcctl_t;

  function automatic logic is_jmp(input logic [15:0] w, input logic [3:0] op);
    return (w[OP_HI:OP_LO] == op);
  endfunction

endpackage

// File: rtl/fetch_redir_reg.sv
// Purpose : holds one pending execute redirect until the sequencer's UPDATE cycle consumes it.
// Latency : set visible on pend_vld/pend_dat the cycle after set_vld.
// Backpressure: none; a new set overwrites any pending redirect (newest wins).
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   set_vld, set_dat  - capture a redirect {sub, off}
//   clr               - drop the pending redirect (consumed)
//   pend_vld, pend_dat- pending flag and payload
module fetch_redir_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   set_vld,
  input  redir_t set_dat,
  input  logic   clr,
  output logic   pend_vld,
  output redir_t pend_dat
);

  // set wins over clr so a redirect arriving while the old one is being
  // consumed is never lost; the sequencer never asserts both together today.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_dat <= '0;
    end else if (set_vld) begin
      pend_vld <= 1'b1;
      pend_dat <= set_dat;
    end else if (clr) begin
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Purpose : fetch sequencer in front of the PC: fetch word at pc, resolve JMPs, apply redirects, hand to decode.
// Latency : FETCH entry to ir_valid = ack wait + 2 cycles; 1 instruction per 3 cycles with zero-wait memory.
// Backpressure: imem_req held until imem_ack; ir held stable with ir_valid until ir_ready.
//
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   pc                             - current PC value
//   inc, add, sub, offset          - PC controls, one-hot-or-zero, only during UPDATE
//   imem_req, imem_addr            - fetch request / address (address = pc while requesting, else 0)
//   imem_ack, imem_data            - memory accept and fetched word
//   ir, ir_valid, ir_ready         - decode handshake
//   redir_valid, redir_sub, redir_off - execute redirect (1-cycle pulse)
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [3:0] JMP_OP = JMP_OP_DEF,
  parameter int         OFF_W  = OFF_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        inc,
  output logic        add,
  output logic        sub,
  output logic [15:0] offset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redir_valid,
  input  logic        redir_sub,
  input  logic [15:0] redir_off
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word;       // capture register for the fetched word
  pcctl_t      ctl;
  logic        load_ir;
  logic        redir_set;
  logic        redir_clr;
  logic        pend_vld;
  redir_t      pend_dat;
  redir_t      live_dat;
  redir_t      sel_dat;

  assign live_dat = '{sub: redir_sub, off: redir_off};

  fetch_redir_reg u_redir (
    .clk      (clk),
    .reset    (reset),
    .set_vld  (redir_set),
    .set_dat  (live_dat),
    .clr      (redir_clr),
    .pend_vld (pend_vld),
    .pend_dat (pend_dat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture is gated by reset, so an ack arriving in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      word <= '0;
    end else if ((state == FETCH) && imem_ack) begin
      word <= imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
    end else if (load_ir) begin
      ir <= word;
    end
  end

  // Next-state and outputs. PC controls are decoded purely from registered
  // state (state, word, pending redirect) except for a redirect pulse that
  // lands in UPDATE itself, which must steer the PC on that same edge.
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    load_ir   = 1'b0;
    redir_set = 1'b0;
    redir_clr = 1'b0;
    imem_req  = 1'b0;
    ir_valid  = 1'b0;
    sel_dat   = redir_valid ? live_dat : pend_dat;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        // Request stays up across a redirect; the redirect waits in the
        // pending register and the fetched word is later discarded.
        imem_req  = 1'b1;
        redir_set = redir_valid;
        if (imem_ack) begin
          state_nxt = UPDATE;
        end
      end

      UPDATE: begin
        redir_clr = 1'b1;
        state_nxt = FETCH;
        if (redir_valid || pend_vld) begin
          ctl.add    = ~sel_dat.sub;
          ctl.sub    = sel_dat.sub;
          ctl.offset = sel_dat.off;
        end else if (is_jmp(word, JMP_OP)) begin
          ctl.sub    = word[OFF_W];
          ctl.add    = ~word[OFF_W];
          ctl.offset = 16'(word[OFF_W-1:0]);
        end else begin
          ctl.inc   = 1'b1;
          load_ir   = 1'b1;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        // A redirect here still lets a same-cycle ir_ready complete: the
        // word is consumed, then UPDATE applies the latched redirect.
        ir_valid = 1'b1;
        if (redir_valid) begin
          redir_set = 1'b1;
          state_nxt = UPDATE;
        end else if (ir_ready) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign inc       = ctl.inc;
  assign add       = ctl.add;
  assign sub       = ctl.sub;
  assign offset    = ctl.offset;
  assign imem_addr = imem_req ? pc : 16'h0000;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        inc, add, sub;
  logic [15:0] offset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        redir_valid;
  logic        redir_sub;
  logic [15:0] redir_off;

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .inc         (inc),
    .add         (add),
    .sub         (sub),
    .offset      (offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_sub   (redir_sub),
    .redir_off   (redir_off)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Environment: memory contents, ack delay, number of fetches to serve.
  logic [15:0] mem [logic [15:0]];
  int          ack_delay = 0;
  int          budget    = 0;

  // Scoreboard queues. Control entries are {inc, add, sub, offset}.
  logic [15:0] q_addr[$];
  logic [18:0] q_ctl[$];
  logic [15:0] q_ir[$];

  localparam logic [2:0] C_INC = 3'b100;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PC register and memory model. PC steps are sampled mid-cycle and applied
  // just after the edge; the ack decision is made with the updated pc.
  initial begin : env
    int          cnt;
    logic [15:0] step;
    cnt       = 0;
    step      = 16'h0000;
    pc        = 16'h0000;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (inc)      step = 16'h0001;
      else if (add) step = offset;
      else if (sub) step = 16'h0000 - offset;
      else          step = 16'h0000;
      @(posedge clk);
      #1;
      pc = pc + step;
      if (imem_req && (budget > 0)) begin
        if (cnt >= ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = mem.exists(pc) ? mem[pc] : 16'h0000;
          cnt       = 0;
          budget--;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 16'h0000;
          cnt++;
        end
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        cnt       = 0;
      end
    end
  end

  // Monitor: compares every observable transaction against the queues.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        check("fetch_expected", 32'(q_addr.size() > 0), 32'd1);
        if (q_addr.size() > 0) check("fetch_addr", 32'(imem_addr), 32'(q_addr.pop_front()));
      end
      if (inc || add || sub) begin
        check("ctl_onehot", 32'($countones({inc, add, sub})), 32'd1);
        check("ctl_expected", 32'(q_ctl.size() > 0), 32'd1);
        if (q_ctl.size() > 0) check("ctl_value", 32'({inc, add, sub, offset}), 32'(q_ctl.pop_front()));
      end else begin
        check("offset_idle_zero", 32'(offset), 32'd0);
      end
      if (ir_valid) begin
        check("ir_expected", 32'(q_ir.size() > 0), 32'd1);
        if (q_ir.size() > 0) begin
          check("ir_value", 32'(ir), 32'(q_ir[0]));
          if (ir_ready) void'(q_ir.pop_front());
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if ((q_addr.size() == 0) && (q_ctl.size() == 0) && (q_ir.size() == 0)) break;
    end
    check({name, "_drained"}, 32'(q_addr.size() + q_ctl.size() + q_ir.size()), 32'd0);
  endtask

  task automatic wait_ir_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (ir_valid) break;
    end
    check({name, "_ir_valid"}, 32'(ir_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_imem_req"}, 32'(imem_req), 32'd0);
    check({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({name, "_ctl"}, 32'({inc, add, sub}), 32'd0);
    check({name, "_offset"}, 32'(offset), 32'd0);
    check({name, "_ir_valid"}, 32'(ir_valid), 32'd0);
    check({name, "_ir"}, 32'(ir), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset       = 1'b1;
    ir_ready    = 1'b0;
    redir_valid = 1'b0;
    redir_sub   = 1'b0;
    redir_off   = 16'h0000;

    // 1: reset, immediate ack, ir held until ir_ready.
    mem[16'h0000] = 16'h1234;
    q_addr.push_back(16'h0000);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h1234);
    budget = 1;
    @(negedge clk);
    check_all_zero("t1_reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t1_req_cycle1", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("t1_req_cycle2", 32'(imem_req), 32'd1);
    check("t1_addr_cycle2", 32'(imem_addr), 32'h0000);
    wait_ir_valid("t1");
    repeat (2) begin
      @(negedge clk);
      check("t1_hold_valid", 32'(ir_valid), 32'd1);
    end
    @(posedge clk); #1 ir_ready = 1'b1;
    wait_drain("t1");

    // 2a: backward JMP 0xF805 at 0x0010 -> 0x000B.
    mem[16'h0010] = 16'hF805;
    mem[16'h000B] = 16'h0042;
    pc = 16'h0010;
    q_addr.push_back(16'h0010);
    q_ctl.push_back({C_SUB, 16'h0005});
    q_addr.push_back(16'h000B);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h0042);
    budget = 2;
    wait_drain("t2a");

    // 2b: forward JMP 0xF005 at 0x0010 -> 0x0015.
    mem[16'h0010] = 16'hF005;
    mem[16'h0015] = 16'h0043;
    pc = 16'h0010;
    q_addr.push_back(16'h0010);
    q_ctl.push_back({C_ADD, 16'h0005});
    q_addr.push_back(16'h0015);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h0043);
    budget = 2;
    wait_drain("t2b");

    // 3: ack delayed 4 cycles.
    mem[16'h0020] = 16'h0ABC;
    pc        = 16'h0020;
    ack_delay = 4;
    q_addr.push_back(16'h0020);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h0ABC);
    budget = 1;
    repeat (4) begin
      @(negedge clk);
      check("t3_req_held", 32'(imem_req), 32'd1);
      check("t3_addr_stable", 32'(imem_addr), 32'h0020);
      check("t3_no_ctl", 32'({inc, add, sub}), 32'd0);
    end
    wait_drain("t3");

    // 4: redirect during fetch wait; fetched word dropped.
    mem[16'h0030] = 16'h5555;
    mem[16'h0130] = 16'h0777;
    pc        = 16'h0030;
    ack_delay = 3;
    q_addr.push_back(16'h0030);
    q_ctl.push_back({C_ADD, 16'h0100});
    q_addr.push_back(16'h0130);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h0777);
    budget = 2;
    @(posedge clk); #1;
    redir_valid = 1'b1; redir_sub = 1'b0; redir_off = 16'h0100;
    @(negedge clk);
    check("t4_req_c1", 32'(imem_req), 32'd1);
    @(posedge clk); #1 redir_valid = 1'b0;
    @(negedge clk);
    check("t4_req_c2", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("t4_req_c3", 32'(imem_req), 32'd1);
    wait_drain("t4");

    // 5a: long HOLD, then redirect together with ir_ready.
    mem[16'h0040] = 16'h1111;
    mem[16'h0039] = 16'h2222;
    pc        = 16'h0040;
    ack_delay = 0;
    q_addr.push_back(16'h0040);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h1111);
    q_ctl.push_back({C_SUB, 16'h0008});
    q_addr.push_back(16'h0039);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h2222);
    budget = 2;
    @(posedge clk); #1 ir_ready = 1'b0;
    wait_ir_valid("t5a");
    repeat (5) begin
      @(negedge clk);
      check("t5a_hold_valid", 32'(ir_valid), 32'd1);
    end
    @(posedge clk); #1;
    ir_ready = 1'b1; redir_valid = 1'b1; redir_sub = 1'b1; redir_off = 16'h0008;
    @(posedge clk); #1 redir_valid = 1'b0;
    @(negedge clk);
    check("t5a_update_sub", 32'(sub), 32'd1);
    check("t5a_update_no_valid", 32'(ir_valid), 32'd0);
    wait_drain("t5a");

    // 5b: two redirects in one FETCH, newest wins.
    mem[16'h0050] = 16'h3333;
    mem[16'h0040] = 16'h4444;
    pc        = 16'h0050;
    ack_delay = 4;
    q_addr.push_back(16'h0050);
    q_ctl.push_back({C_SUB, 16'h0010});
    q_addr.push_back(16'h0040);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h4444);
    budget = 2;
    @(posedge clk); #1;
    redir_valid = 1'b1; redir_sub = 1'b0; redir_off = 16'h0200;
    @(posedge clk); #1 redir_valid = 1'b0;
    @(posedge clk); #1;
    redir_valid = 1'b1; redir_sub = 1'b1; redir_off = 16'h0010;
    @(posedge clk); #1 redir_valid = 1'b0;
    wait_drain("t5b");

    // 6: reset in the ack cycle of a fetch.
    mem[16'h0060] = 16'h6666;
    pc        = 16'h0060;
    ack_delay = 2;
    q_addr.push_back(16'h0060);
    budget = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("t6_after_reset");
    #3;
    mem[16'h0060] = 16'h7777;
    ack_delay     = 0;
    q_addr.push_back(16'h0060);
    q_ctl.push_back({C_INC, 16'h0000});
    q_ir.push_back(16'h7777);
    budget = 1;
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
